alu_seq: RTL

- Parametrised, registered successor to the calculator's combinational ALU.
- Generalises data width and extends the 2-bit op set to eight ops: adds EOR, LSL, LSR and an iterative multi-cycle MUL.
- Produces ARM-style NZCV flags, registered alongside the result.
- Sits between the calculator's operand registers and its result/flag registers; a start/ready/done handshake lets the control FSM issue back-to-back single-cycle ops.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_mul.sv | 52 +++++
 rtl/alu_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: op select, FSM states and NZCV bus layout.
package alu_seq_pkg;

   localparam logic [2:0] FN_ADD = 3'b000;
   localparam logic [2:0] FN_SUB = 3'b001;
   localparam logic [2:0] FN_AND = 3'b010;
   localparam logic [2:0] FN_ORR = 3'b011;
   localparam logic [2:0] FN_EOR = 3'b100;
   localparam logic [2:0] FN_LSL = 3'b101;
   localparam logic [2:0] FN_LSR = 3'b110;
   localparam logic [2:0] FN_MUL = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // NZCV bus is packed {N,Z,C,V}, MSB first
   localparam int unsigned NZCV_W = 4;
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_seq_mul #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             last,
   output logic [WIDTH-1:0] product
);

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] addend;
   logic [SHW-1:0]   cnt;

   // product is the accumulator after the current iteration, so the caller can
   // capture the finished value on the same edge that retires the last bit
   assign addend  = mplier[0] ? mcand : '0;
   assign product = acc + addend;
   assign last    = busy && (cnt == SHW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (go) begin
         busy   <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + SHW'(1);
         if (last) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with NZCV flags; single-cycle logic/arith/shift ops plus an iterative MUL.
module alu_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             n_flag,
   output logic             z_flag,
   output logic             c_flag,
   output logic             v_flag
);

   import alu_seq_pkg::*;

   state_t              state_q, state_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic [NZCV_W-1:0]   flags_q, flags_d;

   logic                mul_go;
   logic                mul_busy;
   logic                mul_last;
   logic [WIDTH-1:0]    mul_product;

   logic [SHW-1:0]      sh;
   logic [WIDTH:0]      sum;
   logic [WIDTH:0]      diff;
   logic [WIDTH:0]      lsl_ext;
   logic [WIDTH:0]      lsr_ext;
   logic [WIDTH-1:0]    op_res;
   logic                op_c;
   logic                op_v;

   alu_seq_mul #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .go      (mul_go),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .last    (mul_last),
      .product (mul_product)
   );

   assign sh = b[SHW-1:0];

   // Single-cycle datapath; shifts carry one guard bit so the last bit out lands there
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      lsl_ext = {1'b0, a} << sh;
      lsr_ext = {a, 1'b0} >> sh;
      op_res  = '0;
      op_c    = 1'b0;
      op_v    = 1'b0;
      case (func)
         FN_ADD: begin
            op_res = sum[WIDTH-1:0];
            op_c   = sum[WIDTH];
            op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         FN_SUB: begin
            op_res = diff[WIDTH-1:0];
            op_c   = ~diff[WIDTH];
            op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         FN_AND: op_res = a & b;
         FN_ORR: op_res = a | b;
         FN_EOR: op_res = a ^ b;
         FN_LSL: begin
            op_res = lsl_ext[WIDTH-1:0];
            op_c   = lsl_ext[WIDTH];
         end
         FN_LSR: begin
            op_res = lsr_ext[WIDTH:1];
            op_c   = lsr_ext[0];
         end
         default: begin
            op_res = '0;
         end
      endcase
   end

   // Handshake FSM and output-register next values
   always_comb begin
      state_d  = state_q;
      ready_d  = ready_q;
      done_d   = 1'b0;
      result_d = result_q;
      flags_d  = flags_q;
      mul_go   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && ready_q) begin
               if (func == FN_MUL) begin
                  mul_go  = 1'b1;
                  state_d = ST_MUL;
                  ready_d = 1'b0;
               end else begin
                  result_d = op_res;
                  flags_d  = {op_res[WIDTH-1], (op_res == '0), op_c, op_v};
                  done_d   = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (mul_last) begin
               result_d = mul_product;
               flags_d  = {mul_product[WIDTH-1], (mul_product == '0), 2'b00};
               done_d   = 1'b1;
               state_d  = ST_IDLE;
               ready_d  = 1'b1;
            end else if (!mul_busy) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // done is masked by rst so a pulse never overlaps a reset cycle
   assign ready  = ready_q;
   assign done   = done_q & ~rst;
   assign result = result_q;
   assign n_flag = flags_q[FLAG_N];
   assign z_flag = flags_q[FLAG_Z];
   assign c_flag = flags_q[FLAG_C];
   assign v_flag = flags_q[FLAG_V];

endmodule
